// File: rtl/watchdog_stall_timer.sv
// Stall watchdog: counts consecutive cycles with no PC change and no kick, warns, then pulses a core reset.
// Optional macro WDT_LOCK_EN: the first arming sets a lock bit that only rst clears, so the watchdog cannot be disabled.
module watchdog_stall_timer #(
    parameter int PC_W        = 32,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_DEF = 16,
    parameter int WARN_MARGIN = 4,
    parameter int RST_PULSE   = 2,
    parameter int HOLDOFF_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wdt_en,
    input  logic [CNT_W-1:0] timeout_val,
    input  logic [PC_W-1:0]  present_pc,
    input  logic [PC_W-1:0]  previous_pc,
    input  logic             kick,
    output logic             warn_irq,
    output logic             watchdog_rst,
    output logic [2:0]       wdt_state,
    output logic [7:0]       fire_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        WARN    = 3'd2,
        FIRE    = 3'd3,
        HOLDOFF = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] T_DEF      = CNT_W'(TIMEOUT_DEF);
    localparam logic [CNT_W-1:0] WM         = CNT_W'(WARN_MARGIN);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0);
    localparam state_e           PULSE_NEXT = (HOLDOFF_CYC == 0) ? ARMED : HOLDOFF;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] t_q, t_d;
    logic             warn_q, warn_d;
    logic             wrst_q, wrst_d;
    logic [7:0]       fire_q, fire_d;
    logic             activity;
    logic             en_eff;

`ifdef WDT_LOCK_EN
    logic lock_q, lock_d;
    assign en_eff = wdt_en | lock_q;
`else
    assign en_eff = wdt_en;
`endif

    assign activity = (present_pc != previous_pc) | kick;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        t_d     = t_q;
        warn_d  = warn_q;
        wrst_d  = wrst_q;
        fire_d  = fire_q;
`ifdef WDT_LOCK_EN
        lock_d  = lock_q;
`endif
        case (state_q)
            IDLE: begin
                count_d = '0;
                warn_d  = 1'b0;
                wrst_d  = 1'b0;
                if (wdt_en) begin
                    state_d = ARMED;
                    t_d     = (timeout_val == '0) ? T_DEF : timeout_val;
`ifdef WDT_LOCK_EN
                    lock_d  = 1'b1;
`endif
                end
            end
            ARMED, WARN: begin
                if (!en_eff) begin
                    state_d = IDLE;
                    count_d = '0;
                    warn_d  = 1'b0;
                end else if (activity) begin
                    // Progress always wins, even on the cycle that would have timed out.
                    state_d = ARMED;
                    count_d = '0;
                    warn_d  = 1'b0;
                end else if (count_q == t_q - ONE) begin
                    state_d = FIRE;
                    count_d = '0;
                    warn_d  = 1'b0;
                    wrst_d  = 1'b1;
                    if (fire_q != 8'hFF) fire_d = fire_q + 8'd1;
                end else begin
                    count_d = count_q + ONE;
                    if (WARN_MARGIN > 0 && WM < t_q && (count_q + ONE) == (t_q - WM)) begin
                        state_d = WARN;
                        warn_d  = 1'b1;
                    end
                end
            end
            FIRE: begin
                // The pulse always runs to full length; disable is honoured only afterwards.
                if (count_q == PULSE_LAST) begin
                    wrst_d  = 1'b0;
                    count_d = '0;
                    state_d = en_eff ? PULSE_NEXT : IDLE;
                end else begin
                    count_d = count_q + ONE;
                end
            end
            HOLDOFF: begin
                if (!en_eff) begin
                    state_d = IDLE;
                    count_d = '0;
                    warn_d  = 1'b0;
                end else if (count_q == HOLD_LAST) begin
                    state_d = ARMED;
                    count_d = '0;
                end else begin
                    count_d = count_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                warn_d  = 1'b0;
                wrst_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            t_q     <= T_DEF;
            warn_q  <= 1'b0;
            wrst_q  <= 1'b0;
            fire_q  <= 8'd0;
`ifdef WDT_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            t_q     <= t_d;
            warn_q  <= warn_d;
            wrst_q  <= wrst_d;
            fire_q  <= fire_d;
`ifdef WDT_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    assign warn_irq     = warn_q;
    assign watchdog_rst = wrst_q;
    assign wdt_state    = state_q;
    assign fire_count   = fire_q;

endmodule

// File: tb/tb_watchdog_stall_timer.sv
// Bench for watchdog_stall_timer: directed scenarios push timed expectations, a negedge monitor checks them.
module tb_watchdog_stall_timer;

    localparam logic [2:0] S_IDLE = 3'd0, S_ARMED = 3'd1, S_WARN = 3'd2,
                           S_FIRE = 3'd3, S_HOLD = 3'd4;
    localparam int W = 53;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wdt_en = 1'b0;
    logic [15:0] timeout_val = '0;
    logic [31:0] present_pc = 32'h100;
    logic [31:0] previous_pc = 32'h100;
    logic        kick = 1'b0;
    logic        warn_irq, watchdog_rst;
    logic [2:0]  wdt_state;
    logic [7:0]  fire_count;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    // Record: {cycle[52:21], id[20:13], state[12:10], warn[9], rst[8], fire_count[7:0]}
    logic [W-1:0] exp_q[$];

    watchdog_stall_timer dut (
        .clk(clk), .rst(rst), .wdt_en(wdt_en), .timeout_val(timeout_val),
        .present_pc(present_pc), .previous_pc(previous_pc), .kick(kick),
        .warn_irq(warn_irq), .watchdog_rst(watchdog_rst),
        .wdt_state(wdt_state), .fire_count(fire_count)
    );

    // Clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int d, input logic [7:0] id, input logic [2:0] st,
                             input logic w, input logic r, input logic [7:0] fc);
        exp_q.push_back({32'(cyc + d), id, st, w, r, fc});
    endtask

    task automatic do_reset(input logic [7:0] id);
        rst = 1'b1;
        wdt_en = 1'b0;
        kick = 1'b0;
        previous_pc = present_pc;
        step(2);
        expect_at(0, id, S_IDLE, 1'b0, 1'b0, 8'd0);
        rst = 1'b0;
    endtask

    // Scoreboard monitor
    logic [W-1:0] e;
    logic [W-1:0] a;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && int'(exp_q[0][52:21]) <= cyc) begin
            e = exp_q.pop_front();
            a = {e[52:13], wdt_state, warn_irq, watchdog_rst, fire_count};
            tests++;
            if (int'(e[52:21]) != cyc || a != e) begin
                fails++;
                $display("FAIL t%0d cyc %0d: got st=%0d warn=%0b rst=%0b fc=%0d, exp st=%0d warn=%0b rst=%0b fc=%0d (exp cyc %0d)",
                         e[20:13], cyc, wdt_state, warn_irq, watchdog_rst, fire_count,
                         e[12:10], e[9], e[8], e[7:0], int'(e[52:21]));
            end
        end
    end

    initial begin
        // 1: default timeout, constant PC
        do_reset(1);
        timeout_val = 16'd0;
        wdt_en = 1'b1;
        expect_at(1, 1, S_ARMED, 0, 0, 0);
        expect_at(12, 1, S_ARMED, 0, 0, 0);
        expect_at(13, 1, S_WARN, 1, 0, 0);
        expect_at(16, 1, S_WARN, 1, 0, 0);
        expect_at(17, 1, S_FIRE, 0, 1, 1);
        expect_at(18, 1, S_FIRE, 0, 1, 1);
        expect_at(19, 1, S_HOLD, 0, 0, 1);
        expect_at(21, 1, S_HOLD, 0, 0, 1);
        expect_at(22, 1, S_ARMED, 0, 0, 1);
        step(22);

        // 2: PC advances every 10 cycles, never fires
        do_reset(2);
        wdt_en = 1'b1;
        step(1);
        for (int i = 0; i < 300; i++) begin
            previous_pc = present_pc;
            if (i % 10 == 0) present_pc = present_pc + 32'd4;
            expect_at(1, 2, S_ARMED, 0, 0, 0);
            step(1);
        end
        previous_pc = present_pc;

        // 3: timeout 8, timeout_val change mid-count ignored
        do_reset(3);
        timeout_val = 16'd8;
        wdt_en = 1'b1;
        expect_at(1, 3, S_ARMED, 0, 0, 0);
        expect_at(4, 3, S_ARMED, 0, 0, 0);
        expect_at(5, 3, S_WARN, 1, 0, 0);
        expect_at(8, 3, S_WARN, 1, 0, 0);
        expect_at(9, 3, S_FIRE, 0, 1, 1);
        expect_at(11, 3, S_HOLD, 0, 0, 1);
        expect_at(14, 3, S_ARMED, 0, 0, 1);
        expect_at(17, 3, S_ARMED, 0, 0, 1);
        expect_at(18, 3, S_WARN, 1, 0, 1);
        expect_at(21, 3, S_WARN, 1, 0, 1);
        expect_at(22, 3, S_FIRE, 0, 1, 2);
        step(3);
        timeout_val = 16'd100;
        step(19);

        // 4: kick on the 16th inactive sample beats the timeout
        do_reset(4);
        timeout_val = 16'd0;
        wdt_en = 1'b1;
        expect_at(13, 4, S_WARN, 1, 0, 0);
        expect_at(16, 4, S_WARN, 1, 0, 0);
        expect_at(17, 4, S_ARMED, 0, 0, 0);
        expect_at(18, 4, S_ARMED, 0, 0, 0);
        expect_at(28, 4, S_ARMED, 0, 0, 0);
        expect_at(29, 4, S_WARN, 1, 0, 0);
        step(16);
        kick = 1'b1;
        step(1);
        kick = 1'b0;
        step(12);

        // 5: disable during WARN
        do_reset(5);
        wdt_en = 1'b1;
        expect_at(13, 5, S_WARN, 1, 0, 0);
`ifdef WDT_LOCK_EN
        expect_at(14, 5, S_WARN, 1, 0, 0);
        expect_at(17, 5, S_FIRE, 0, 1, 1);
`else
        expect_at(14, 5, S_IDLE, 0, 0, 0);
        expect_at(17, 5, S_IDLE, 0, 0, 0);
`endif
        step(13);
        wdt_en = 1'b0;
        step(4);

        // 6a: reset during first FIRE cycle
        do_reset(6);
        wdt_en = 1'b1;
        expect_at(17, 6, S_FIRE, 0, 1, 1);
        expect_at(18, 6, S_IDLE, 0, 0, 0);
        step(17);
        rst = 1'b1;
        step(1);
        rst = 1'b0;

        // 6b: T=1, repeated fires saturate fire_count at 255
        timeout_val = 16'd1;
        for (int k = 1; k <= 260; k++)
            expect_at(2 + 6 * (k - 1), 7, S_FIRE, 0, 1, (k > 255) ? 8'd255 : 8'(k));
        step(2 + 6 * 259);
        step(3);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
